// File: rtl/mem_pkg.sv
// Shared encodings and widths for the memory responder slice.
package mem_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Word-wide storage: synchronous write port, registered read port.
// Contents survive reset; only the read register is cleared.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Zeroed once at start of simulation, never by rst_ni.
    logic [DATA_W-1:0] mem_q [2**ADDR_W] = '{default: '0};
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: IDLE -> ACCESS -> RESP handshake.
// Optional macro MEM_WAIT_STATES_EN stretches ACCESS to WAIT_CYCLES+1 cycles.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] Mem_Data_Out,
    output logic              Mem_Ready,
    output logic              Mem_Busy,
    output logic              Req_Error
);

    if (WAIT_CYCLES > 15) begin : g_wait_range
        $error("mem_responder: WAIT_CYCLES must be in 0..15");
    end

    mem_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              is_write_q;
    logic              ready_q;
    logic              busy_q;
    logic              err_q;
    logic              last_access;
    logic              arr_we;
    logic              arr_re;

`ifdef MEM_WAIT_STATES_EN
    logic [3:0] cnt_q;
    assign last_access = (state_q == ACCESS) && (cnt_q == '0);
`else
    assign last_access = (state_q == ACCESS);
`endif

    // Array write and read capture both land on the final ACCESS edge.
    assign arr_we = last_access && is_write_q;
    assign arr_re = last_access && !is_write_q;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
            cnt_q      <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Read && Write) begin
                        err_q <= 1'b1;
                    end else if (Read || Write) begin
                        addr_q     <= Address;
                        wdata_q    <= Write_Data;
                        is_write_q <= Write;
                        busy_q     <= 1'b1;
                        state_q    <= ACCESS;
`ifdef MEM_WAIT_STATES_EN
                        cnt_q      <= 4'(WAIT_CYCLES);
`endif
                    end
                end
                ACCESS: begin
                    if (last_access) begin
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end
`ifdef MEM_WAIT_STATES_EN
                    else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
`endif
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (Clock),
        .rst_ni  (Clear),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (Mem_Data_Out)
    );

    assign Mem_Ready = ready_q;
    assign Mem_Busy  = busy_q;
    assign Req_Error = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (WAIT_CYCLES=3); honours MEM_WAIT_STATES_EN.
module tb_mem_responder;

    localparam int unsigned WAITS = 3;
`ifdef MEM_WAIT_STATES_EN
    localparam int ACC     = WAITS + 1;
    localparam int EXP_LAT = 5;
`else
    localparam int ACC     = 1;
    localparam int EXP_LAT = 2;
`endif

    logic        Clock;
    logic        Clear;
    logic [8:0]  Address;
    logic [31:0] Write_Data;
    logic        Read;
    logic        Write;
    logic [31:0] Mem_Data_Out;
    logic        Mem_Ready;
    logic        Mem_Busy;
    logic        Req_Error;

    int checks   = 0;
    int failures = 0;

    mem_responder #(
        .ADDR_W      (9),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .Clock        (Clock),
        .Clear        (Clear),
        .Address      (Address),
        .Write_Data   (Write_Data),
        .Read         (Read),
        .Write        (Write),
        .Mem_Data_Out (Mem_Data_Out),
        .Mem_Ready    (Mem_Ready),
        .Mem_Busy     (Mem_Busy),
        .Req_Error    (Req_Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted request completes ACC edges later,
    // the following cycle is the response cycle, then the responder is free.
    logic [31:0] mmem [512];
    int          m_left = 0;
    bit          m_resp = 0;
    bit          m_wr   = 0;
    logic [8:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic        exp_ready = 0, exp_busy = 0, exp_err = 0;
    logic [31:0] exp_data = '0;

    initial for (int i = 0; i < 512; i++) mmem[i] = '0;

    always @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            m_left = 0; m_resp = 0;
            exp_ready = 0; exp_busy = 0; exp_err = 0; exp_data = '0;
        end else begin
            exp_ready = 0; exp_err = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_wr) mmem[m_addr] = m_data;
                    else      exp_data = mmem[m_addr];
                    exp_ready = 1; m_resp = 1;
                end
            end else if (m_resp) begin
                m_resp = 0;
            end else if (Read && Write) begin
                exp_err = 1;
            end else if (Read || Write) begin
                m_wr = Write; m_addr = Address; m_data = Write_Data; m_left = ACC;
            end
            exp_busy = (m_left > 0) || m_resp;
        end
    end

    always @(negedge Clock) begin
        if ($time > 0) begin
            chk("cyc_ready", {31'd0, Mem_Ready}, {31'd0, exp_ready});
            chk("cyc_busy",  {31'd0, Mem_Busy},  {31'd0, exp_busy});
            chk("cyc_error", {31'd0, Req_Error}, {31'd0, exp_err});
            chk("cyc_data",  Mem_Data_Out, exp_data);
        end
    end

    // Called just after the sampling edge; that edge counts as edge 1.
    task automatic wait_ready(output int n);
        n = 1;
        while (!Mem_Ready && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
    endtask

    task automatic wait_idle();
        @(negedge Clock);
        for (int i = 0; i < 30 && Mem_Busy; i++) @(negedge Clock);
    endtask

    task automatic do_access(input bit wr, input logic [8:0] a, input logic [31:0] d,
                             input string nm);
        int n;
        wait_idle();
        Address = a; Write_Data = d; Write = wr; Read = !wr;
        @(posedge Clock); #1;
        Address = ~a; Write_Data = ~d;
        wait_ready(n);
        chk({nm, "_lat"}, n, EXP_LAT);
        @(negedge Clock);
        Read = 0; Write = 0;
    endtask

    initial begin
        int n;
        Read = 0; Write = 0; Address = '0; Write_Data = '0;
        Clear = 1;
        #1 Clear = 0;
        #16 Clear = 1;
        @(negedge Clock);
        chk("rst_data",  Mem_Data_Out, 32'h0);
        chk("rst_ready", {31'd0, Mem_Ready}, 32'h0);
        chk("rst_busy",  {31'd0, Mem_Busy},  32'h0);
        chk("rst_error", {31'd0, Req_Error}, 32'h0);

        do_access(1, 9'h010, 32'h4A920000, "wr010");
        chk("wr_keeps_data", Mem_Data_Out, 32'h0);
        do_access(0, 9'h010, 32'h0, "rd010");
        chk("rd010_data", Mem_Data_Out, 32'h4A920000);
        chk("model_pin_010", exp_data, 32'h4A920000);
        do_access(0, 9'h1FF, 32'h0, "rd1FF");
        chk("rd1FF_data", Mem_Data_Out, 32'h0);
        do_access(1, 9'h000, 32'h00000022, "wr000");
        do_access(0, 9'h000, 32'h0, "rd000");
        chk("rd000_data", Mem_Data_Out, 32'h00000022);

        wait_idle();
        Address = 9'h010; Write_Data = 32'hDEADBEEF; Read = 1; Write = 1;
        @(posedge Clock); #1;
        chk("both_err",  {31'd0, Req_Error}, 32'h1);
        chk("both_busy", {31'd0, Mem_Busy},  32'h0);
        @(negedge Clock);
        Read = 0; Write = 0;
        @(posedge Clock); #1;
        chk("both_err_end", {31'd0, Req_Error}, 32'h0);
        do_access(0, 9'h010, 32'h0, "rd010b");
        chk("rd010b_data", Mem_Data_Out, 32'h4A920000);

        wait_idle();
        Address = 9'h005; Write_Data = 32'h00000026; Write = 1;
        @(posedge Clock);
        @(negedge Clock); #2;
        Clear = 0; Write = 0;
        #4;
        chk("abort_busy", {31'd0, Mem_Busy}, 32'h0);
        chk("abort_data", Mem_Data_Out, 32'h0);
        chk("abort_ready", {31'd0, Mem_Ready}, 32'h0);
        #6 Clear = 1;
        do_access(0, 9'h005, 32'h0, "rd005");
        chk("rd005_data", Mem_Data_Out, 32'h0);
        do_access(0, 9'h1FF, 32'h0, "rd1FFb");

        wait_idle();
        Address = 9'h010; Read = 1;
        @(posedge Clock); #1;
        wait_ready(n);
        chk("hold1_lat", n, EXP_LAT);
        chk("hold1_data", Mem_Data_Out, 32'h4A920000);
        @(posedge Clock); #1;
        chk("hold_gap_busy", {31'd0, Mem_Busy}, 32'h0);
        @(posedge Clock); #1;
        chk("hold_restart_busy", {31'd0, Mem_Busy}, 32'h1);
        wait_ready(n);
        chk("hold2_lat", n, EXP_LAT);
        chk("hold2_data", Mem_Data_Out, 32'h4A920000);
        @(negedge Clock);
        Read = 0;
        repeat (3) @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
